modexp_sequencer: RTL and testbench

//  Square-and-multiply controller computing msg = cipher^privKey mod modulos.

---
 rtl/modexp_pkg.sv | 25 ++
 rtl/key_bit_scanner.sv | 40 ++++
 rtl/modexp_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_modexp_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types for the modular-exponentiation sequencer: FSM states, multiplier
// operation selects and default widths.
package modexp_pkg;

    localparam int unsigned DefKeySize = 16;
    localparam int unsigned DefMsgSize = 16;
    localparam int unsigned DefModSize = 16;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StReduce,
        StSkip,
        StSquare,
        StMult,
        StFinish
    } state_e;

    typedef enum logic [1:0] {
        OP_RED,
        OP_SQR,
        OP_MUL
    } op_sel_e;

endpackage

// File: rtl/key_bit_scanner.sv
// Walks the latched exponent from MSB to LSB; exposes the bit under the cursor
// together with last-position and all-zero flags.
module key_bit_scanner #(
    parameter int unsigned KEYSIZE = 16,
    localparam int unsigned IdxW = (KEYSIZE > 1) ? $clog2(KEYSIZE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [KEYSIZE-1:0] key,
    output logic               cur_bit,
    output logic               last,
    output logic               zero
);

    logic [IdxW-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load) begin
            idx_d = IdxW'(KEYSIZE - 1);
        end else if (dec && (idx_q != '0)) begin
            idx_d = idx_q - IdxW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign cur_bit = key[idx_q];
    assign last    = (idx_q == '0);
    assign zero    = (key == '0);

endmodule

// File: rtl/modexp_sequencer.sv
// Square-and-multiply controller: msg = cipher^privKey mod modulos, issuing one
// modular multiply at a time to an external multiplier over req/ack.
module modexp_sequencer
    import modexp_pkg::*;
#(
    parameter int unsigned KEYSIZE = DefKeySize,
    parameter int unsigned MSGSIZE = DefMsgSize,
    parameter int unsigned MODSIZE = DefModSize
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEYSIZE-1:0] privKey,
    input  logic [MSGSIZE-1:0] cipher,
    input  logic [MODSIZE-1:0] modulos,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [MSGSIZE-1:0] msg,
    output logic               mm_req,
    output logic [MODSIZE-1:0] mm_a,
    output logic [MODSIZE-1:0] mm_b,
    output logic [MODSIZE-1:0] mm_n,
    input  logic               mm_ack,
    input  logic [MODSIZE-1:0] mm_p
);

    state_e             state_q, state_d;
    logic [KEYSIZE-1:0] key_q, key_d;
    logic [MSGSIZE-1:0] cipher_q, cipher_d;
    logic [MODSIZE-1:0] base_q, base_d;
    logic [MODSIZE-1:0] acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [MSGSIZE-1:0] msg_q, msg_d;
    logic               mm_req_q, mm_req_d;
    logic [MODSIZE-1:0] mm_a_q, mm_a_d;
    logic [MODSIZE-1:0] mm_b_q, mm_b_d;
    logic [MODSIZE-1:0] mm_n_q, mm_n_d;

    op_sel_e            op_sel;
    logic [MODSIZE-1:0] op_a, op_b;
    logic               op_done;
    logic               scan_load, scan_dec, scan_bit, scan_last, scan_zero;
    logic               step, fin;
    logic [MODSIZE-1:0] step_val;
    logic [MSGSIZE-1:0] fin_msg;

    key_bit_scanner #(
        .KEYSIZE(KEYSIZE)
    ) u_scanner (
        .clk    (clk),
        .rst    (rst),
        .load   (scan_load),
        .dec    (scan_dec),
        .key    (key_q),
        .cur_bit(scan_bit),
        .last   (scan_last),
        .zero   (scan_zero)
    );

    always_comb begin
        case (state_q)
            StSquare: op_sel = OP_SQR;
            StMult:   op_sel = OP_MUL;
            default:  op_sel = OP_RED;
        endcase
        unique case (op_sel)
            OP_SQR: begin
                op_a = acc_q;
                op_b = acc_q;
            end
            OP_MUL: begin
                op_a = acc_q;
                op_b = base_q;
            end
            default: begin
                op_a = MODSIZE'(cipher_q);
                op_b = MODSIZE'(1);
            end
        endcase
    end

    // Acks are only honoured while our own request is outstanding.
    assign op_done = mm_req_q && mm_ack;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        cipher_d  = cipher_q;
        base_d    = base_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        msg_d     = msg_q;
        mm_req_d  = mm_req_q;
        mm_a_d    = mm_a_q;
        mm_b_d    = mm_b_q;
        mm_n_d    = mm_n_q;
        scan_load = 1'b0;
        scan_dec  = 1'b0;
        step      = 1'b0;
        step_val  = mm_p;
        fin       = 1'b0;
        fin_msg   = '0;

        // Entering an op state with req low means the op has not been issued yet.
        if ((state_q inside {StReduce, StSquare, StMult}) && !mm_req_q) begin
            mm_req_d = 1'b1;
            mm_a_d   = op_a;
            mm_b_d   = op_b;
        end
        if (op_done) begin
            mm_req_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    key_d     = privKey;
                    cipher_d  = cipher;
                    mm_n_d    = modulos;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    scan_load = 1'b1;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                if (mm_n_q == '0) begin
                    err_d = 1'b1;
                    fin   = 1'b1;
                end else if (mm_n_q == MODSIZE'(1)) begin
                    fin = 1'b1;
                end else if (scan_zero) begin
                    fin_msg = MSGSIZE'(1);
                    fin     = 1'b1;
                end else begin
                    state_d = StReduce;
                end
            end
            StReduce: begin
                if (op_done) begin
                    base_d  = mm_p;
                    state_d = StSkip;
                end
            end
            StSkip: begin
                if (scan_bit) begin
                    acc_d    = base_q;
                    step     = 1'b1;
                    step_val = base_q;
                end else begin
                    scan_dec = 1'b1;
                end
            end
            StSquare: begin
                if (op_done) begin
                    acc_d = mm_p;
                    if (scan_bit) begin
                        state_d = StMult;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            StMult: begin
                if (op_done) begin
                    acc_d = mm_p;
                    step  = 1'b1;
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (step) begin
            if (scan_last) begin
                fin     = 1'b1;
                fin_msg = step_val[MSGSIZE-1:0];
            end else begin
                scan_dec = 1'b1;
                state_d  = StSquare;
            end
        end

        if (fin) begin
            msg_d   = fin_msg;
            done_d  = 1'b1;
            state_d = StFinish;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            key_q    <= '0;
            cipher_q <= '0;
            base_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            msg_q    <= '0;
            mm_req_q <= 1'b0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            mm_n_q   <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            cipher_q <= cipher_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            msg_q    <= msg_d;
            mm_req_q <= mm_req_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
            mm_n_q   <= mm_n_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign msg    = msg_q;
    assign mm_req = mm_req_q;
    assign mm_a   = mm_a_q;
    assign mm_b   = mm_b_q;
    assign mm_n   = mm_n_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Scoreboard bench for modexp_sequencer with a random-latency modular multiplier model.
module tb_modexp_sequencer;

    localparam int unsigned KS = 16;
    localparam int unsigned MS = 16;
    localparam int unsigned NS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KS-1:0] privKey;
    logic [MS-1:0] cipher;
    logic [NS-1:0] modulos;
    logic          busy, done, err;
    logic [MS-1:0] msg;
    logic          mm_req;
    logic [NS-1:0] mm_a, mm_b, mm_n;
    logic          mm_ack;
    logic [NS-1:0] mm_p;

    modexp_sequencer #(
        .KEYSIZE(KS),
        .MSGSIZE(MS),
        .MODSIZE(NS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .privKey(privKey),
        .cipher (cipher),
        .modulos(modulos),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .msg    (msg),
        .mm_req (mm_req),
        .mm_a   (mm_a),
        .mm_b   (mm_b),
        .mm_n   (mm_n),
        .mm_ack (mm_ack),
        .mm_p   (mm_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MS-1:0] msg;
        logic          err;
        int            ops;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    int   ack_base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Multiplier model: accepts a request, acks after 1..8 cycles, drops work on rst.
    initial begin
        logic          mbusy;
        int            cnt;
        logic [NS-1:0] ca, cb, cn;
        mbusy  = 1'b0;
        cnt    = 0;
        ca     = '0;
        cb     = '0;
        cn     = '0;
        mm_ack = 1'b0;
        mm_p   = '0;
        forever begin
            @(negedge clk);
            mm_ack = 1'b0;
            if (rst) begin
                mbusy = 1'b0;
            end else if (mbusy) begin
                if (!mm_req) begin
                    mbusy = 1'b0;
                end else if (cnt == 0) begin
                    check("operands_stable", {mm_a, mm_b}, {ca, cb});
                    mm_ack = 1'b1;
                    mm_p   = (cn == '0) ? '0 : NS'((64'(ca) * 64'(cb)) % 64'(cn));
                    ack_cnt++;
                    mbusy  = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mm_req) begin
                ca    = mm_a;
                cb    = mm_b;
                cn    = mm_n;
                cnt   = int'($urandom_range(7, 0));
                mbusy = 1'b1;
            end
        end
    end

    // Monitor: every done pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with msg %0d, expected no done", msg);
            end else begin
                e = exp_q.pop_front();
                check("msg", 32'(msg), 32'(e.msg));
                check("err", 32'(err), 32'(e.err));
                check("op_count", ack_cnt - ack_base, e.ops);
                ack_base = ack_cnt;
            end
        end
    end

    task automatic launch(input logic [MS-1:0] c, input logic [KS-1:0] d,
                          input logic [NS-1:0] n, input logic [MS-1:0] em,
                          input logic ee, input int eops, input bit push);
        exp_t e;
        e.msg = em;
        e.err = ee;
        e.ops = eops;
        if (push) exp_q.push_back(e);
        cipher  = c;
        privKey = d;
        modulos = n;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name, output int cyc, output logic saw_req);
        cyc     = 1;
        saw_req = 1'b0;
        while (!done && cyc < 4000) begin
            saw_req = saw_req | mm_req;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, cyc);
            exp_q.delete();
            do_reset();
        end else begin
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_cleared", 32'(busy), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_base = ack_cnt;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_msg", 32'(msg), 32'd0);
        check("rst_mm_req", 32'(mm_req), 32'd0);
        check("rst_mm_a", 32'(mm_a), 32'd0);
        check("rst_mm_b", 32'(mm_b), 32'd0);
        check("rst_mm_n", 32'(mm_n), 32'd0);
    endtask

    task automatic run(input string name, input logic [MS-1:0] c, input logic [KS-1:0] d,
                       input logic [NS-1:0] n, input logic [MS-1:0] em,
                       input logic ee, input int eops);
        int   cyc;
        logic saw;
        launch(c, d, n, em, ee, eops, 1'b1);
        wait_done(name, cyc, saw);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish by 500us, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        logic saw;
        int   n;

        rst     = 1'b1;
        start   = 1'b0;
        privKey = '0;
        cipher  = '0;
        modulos = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        run("c4_d13", 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 6);
        run("rsa_3233", 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 16);
        run("reduce_only", 16'd500, 16'd1, 16'd497, 16'd3, 1'b0, 1);
        run("key_zero", 16'd7, 16'd0, 16'd497, 16'd1, 1'b0, 0);
        run("c3_d5", 16'd3, 16'd5, 16'd7, 16'd5, 1'b0, 4);

        // Zero modulus: error path, no multiplier traffic, fixed latency.
        launch(16'd9, 16'd5, 16'd0, 16'd0, 1'b1, 0, 1'b1);
        wait_done("mod_zero", cyc, saw);
        check("mod_zero_latency", cyc, 2);
        check("mod_zero_no_req", 32'(saw), 32'd0);

        // Back-to-back start right after done; err must clear on accept.
        launch(16'd9, 16'd5, 16'd1, 16'd0, 1'b0, 0, 1'b1);
        check("err_cleared", 32'(err), 32'd0);
        wait_done("mod_one", cyc, saw);

        // Start while busy must be ignored.
        launch(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 6, 1'b1);
        repeat (4) @(negedge clk);
        cipher  = 16'd7;
        privKey = 16'd0;
        modulos = 16'd5;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done("busy_start", cyc, saw);
        repeat (20) @(negedge clk);

        // Reset while the first SQUARE request is outstanding.
        launch(16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 16, 1'b0);
        n = 0;
        while (!((ack_cnt - ack_base) >= 1 && mm_req) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_square", 32'((ack_cnt - ack_base) >= 1 && mm_req), 32'd1);
        do_reset();
        check_reset_outputs();
        repeat (5) @(negedge clk);
        check("no_done_after_reset_idle", 32'(busy), 32'd0);
        run("rsa_after_reset", 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 16);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
